// File: rtl/mem_access_lsu.sv
// mem_access_lsu: memory-access stage between Execute and Write Back.
// It issues a request/grant/response data-memory access with lane-aligned
// store data and byte enables, and aligns and extends load data. It also traps
// misaligned or illegal accesses, bus errors and timeouts, and stalls the pipe
// while an access is outstanding.
module mem_access_lsu #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clk_en,
  input  logic                  i_ex_mem_to_reg,
  input  logic                  i_ex_reg_wr,
  input  logic                  i_ex_mem_rd,
  input  logic                  i_ex_mem_wr,
  input  logic [1:0]            i_ex_rw_sel,
  input  logic [XLEN-1:0]       i_ex_pc_plus_4,
  input  logic [XLEN-1:0]       i_ex_alu_result,
  input  logic [XLEN-1:0]       i_ex_reg_read_data2,
  input  logic [REG_ADDR_W-1:0] i_ex_reg_dest,
  input  logic [2:0]            i_ex_funct3,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [XLEN-1:0]       o_mem_addr,
  output logic [XLEN-1:0]       o_mem_wdata,
  output logic [XLEN/8-1:0]     o_mem_be,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [XLEN-1:0]       i_mem_rdata,
  input  logic                  i_mem_err,
  output logic                  o_stall,
  output logic                  o_ma_mem_to_reg,
  output logic                  o_ma_reg_wr,
  output logic [1:0]            o_ma_rw_sel,
  output logic [XLEN-1:0]       o_ma_pc_plus_4,
  output logic [XLEN-1:0]       o_ma_result,
  output logic [XLEN-1:0]       o_ma_read_data,
  output logic [REG_ADDR_W-1:0] o_ma_reg_dest,
  output logic                  o_ma_exc,
  output logic [1:0]            o_ma_exc_cause
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int TO_W  = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  // Byte-lane mask of an access before it is shifted to its offset.
  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = BE_W'(1);
      2'b01:   size_mask = BE_W'(3);
      2'b10:   size_mask = BE_W'(15);
      default: size_mask = '1;
    endcase
  endfunction

  // Offset must be a multiple of the access size; D and LWU exist only on RV64,
  // and funct3=111 is never a valid load/store.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [OFF_W-1:0] off);
    logic bad;
    case (f3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off[1:0] != 2'b00);
      default: bad = (off != '0);
    endcase
    if (XLEN == 32 && (f3[1:0] == 2'b11 || f3 == 3'b110)) bad = 1'b1;
    if (f3 == 3'b111) bad = 1'b1;
    return bad;
  endfunction

  // Sign- or zero-extend the low bytes of an already right-aligned load word.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] word,
                                                  input logic [1:0] sz, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [XLEN-1:0]    r;
    b = word[7:0];
    h = word[15:0];
    w = word[31:0];
    case (sz)
      2'b00:   if (uns) r = XLEN'(word[7:0]);  else r = XLEN'(b);
      2'b01:   if (uns) r = XLEN'(word[15:0]); else r = XLEN'(h);
      2'b10:   if (uns) r = XLEN'(word[31:0]); else r = XLEN'(w);
      default: r = word;
    endcase
    return r;
  endfunction

  state_t                 state;
  logic [TO_W-1:0]        to_cnt;
  logic                   hold_err_p1;
  logic [XLEN-1:0]        hold_data_p1;
  logic                   req_we_p1, req_ld_p1, req_uns_p1;
  logic [XLEN-1:0]        req_addr_p1, req_wdata_p1;
  logic [BE_W-1:0]        req_be_p1;
  logic [OFF_W-1:0]       req_off_p1;
  logic [1:0]             req_sz_p1;

  // Stage p0: decode of the access presented by Execute.
  logic                   ex_access, ex_misal, ex_we, issue_now;
  logic [OFF_W-1:0]       ex_off;
  logic [XLEN-1:0]        ex_addr, ex_wdata;
  logic [BE_W-1:0]        ex_be;

  assign ex_access = i_ex_mem_rd | i_ex_mem_wr;
  assign ex_off    = i_ex_alu_result[OFF_W-1:0];
  assign ex_misal  = is_misaligned(i_ex_funct3, ex_off);
  assign ex_we     = i_ex_mem_wr & ~i_ex_mem_rd;
  assign ex_addr   = {i_ex_alu_result[XLEN-1:OFF_W], OFF_W'(0)};
  assign ex_wdata  = i_ex_reg_read_data2 << {ex_off, 3'b000};
  assign ex_be     = size_mask(i_ex_funct3[1:0]) << ex_off;
  assign issue_now = (state == IDLE) && ex_access && !ex_misal && !i_rst;

  // Stage p1: outstanding access, completion and load alignment.
  logic                   busy, to_hit, rsp_hit, fin, fin_err;
  logic [XLEN-1:0]        ld_data;

  assign busy    = (state == REQ) || (state == RSP);
  assign to_hit  = (TIMEOUT != 0) && busy && (to_cnt == TO_W'(TIMEOUT - 1));
  assign rsp_hit = (state == RSP) && i_mem_rvalid;
  assign fin     = rsp_hit || to_hit;
  assign fin_err = !rsp_hit || i_mem_err;
  assign ld_data = extend_load(i_mem_rdata >> {req_off_p1, 3'b000}, req_sz_p1, req_uns_p1);

  // Memory port and stall: live EX values while idle, registered copies afterwards.
  always_comb begin
    o_mem_we    = req_we_p1;
    o_mem_addr  = req_addr_p1;
    o_mem_wdata = req_wdata_p1;
    o_mem_be    = req_be_p1;
    if (state == IDLE) begin
      o_mem_we    = ex_we;
      o_mem_addr  = ex_addr;
      o_mem_wdata = ex_wdata;
      o_mem_be    = ex_be;
    end
    o_mem_req = issue_now || ((state == REQ) && !to_hit && !i_rst);
    case (state)
      IDLE:    o_stall = issue_now;
      DONE:    o_stall = !i_clk_en;
      default: o_stall = !(fin && i_clk_en);
    endcase
    if (i_rst) o_stall = 1'b0;
  end

  // Result fields the WB register takes when the pipe advances.
  logic            wb_reg_wr, wb_exc;
  logic [1:0]      wb_cause;
  logic [XLEN-1:0] wb_read;

  always_comb begin
    wb_reg_wr = i_ex_reg_wr;
    wb_read   = '0;
    wb_exc    = 1'b0;
    wb_cause  = 2'b00;
    case (state)
      IDLE: if (ex_access && ex_misal) begin
        wb_reg_wr = 1'b0;
        wb_exc    = 1'b1;
        wb_cause  = i_ex_mem_rd ? 2'b01 : 2'b10;
      end
      DONE: if (hold_err_p1) begin
        wb_reg_wr = 1'b0;
        wb_exc    = 1'b1;
        wb_cause  = 2'b11;
      end else begin
        wb_read = hold_data_p1;
      end
      default: if (fin_err) begin
        wb_reg_wr = 1'b0;
        wb_exc    = 1'b1;
        wb_cause  = 2'b11;
      end else if (req_ld_p1) begin
        wb_read = ld_data;
      end
    endcase
  end

  // Handshake FSM, timeout counter and holding register for frozen-pipe responses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      to_cnt       <= '0;
      hold_err_p1  <= 1'b0;
      hold_data_p1 <= '0;
    end else begin
      case (state)
        IDLE: if (issue_now) begin
          state  <= i_mem_gnt ? RSP : REQ;
          to_cnt <= '0;
        end
        REQ, RSP: if (fin) begin
          state <= i_clk_en ? IDLE : DONE;
          if (!i_clk_en) begin
            hold_err_p1  <= fin_err;
            hold_data_p1 <= (fin_err || !req_ld_p1) ? '0 : ld_data;
          end
        end else if (state == REQ && i_mem_gnt) begin
          state  <= RSP;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
        default: if (i_clk_en) state <= IDLE;
      endcase
    end
  end

  // Registered request copy, held stable while the access is outstanding.
  always_ff @(posedge i_clk) begin
    if (issue_now) begin
      req_we_p1    <= ex_we;
      req_addr_p1  <= ex_addr;
      req_wdata_p1 <= ex_wdata;
      req_be_p1    <= ex_be;
      req_off_p1   <= ex_off;
      req_sz_p1    <= i_ex_funct3[1:0];
      req_uns_p1   <= i_ex_funct3[2];
      req_ld_p1    <= i_ex_mem_rd;
    end
  end

  // Stage p2: MA/WB pipeline register, advanced only when the pipe moves.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ma_mem_to_reg <= 1'b0;
      o_ma_reg_wr     <= 1'b0;
      o_ma_rw_sel     <= 2'b00;
      o_ma_pc_plus_4  <= '0;
      o_ma_result     <= '0;
      o_ma_read_data  <= '0;
      o_ma_reg_dest   <= '0;
      o_ma_exc        <= 1'b0;
      o_ma_exc_cause  <= 2'b00;
    end else if (i_clk_en && !o_stall) begin
      o_ma_mem_to_reg <= i_ex_mem_to_reg;
      o_ma_reg_wr     <= wb_reg_wr;
      o_ma_rw_sel     <= i_ex_rw_sel;
      o_ma_pc_plus_4  <= i_ex_pc_plus_4;
      o_ma_result     <= i_ex_alu_result;
      o_ma_read_data  <= wb_read;
      o_ma_reg_dest   <= i_ex_reg_dest;
      o_ma_exc        <= wb_exc;
      o_ma_exc_cause  <= wb_cause;
    end
  end

endmodule
